countd_bcd: RTL and testbench
=============================

Name: countd_bcd

Overview:
- Synchronous, cascadable, multi-digit BCD down counter. It is the count-down counterpart of the team's decade up-counter.
- Used for countdown timers and terminal-count event generation.
- Supports parallel load, count enable, stop-at-zero or wrap mode, and a registered wrap pulse for chaining counters.
- Every flop is clocked on posedge clk; there are no ripple clocks.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); counter width is 4*DIGITS.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- reset  input  1  reset, asynchronous, active-high.
- load  input  1  parallel load strobe.
- load_val  input  4*DIGITS  packed BCD load value; digit 0 is at [3:0].
- en  input  1  count enable; decrements by 1 per enabled cycle.
- stop_at_zero  input  1  1 = hold at 0 when it is reached; 0 = wrap 0 -> all-9s.
- q  output  4*DIGITS  current count, packed BCD, registered.
- zero  output  1  high when q == 0; decoded directly from the q flops.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a 0 -> all-9s wrap.
- load_err  output  1  registered one-cycle pulse, high in the cycle after a load that contained a non-BCD digit.

Behaviour:
- Reset: while reset is high, regardless of clk, q=0, wrap=0, load_err=0. zero=1 follows from q=0. Deassertion is synchronous to clk; the first count can happen on the first posedge after reset falls.
- Priority at each posedge: reset > load > en > hold.
- Load:
  - q <= load_val, digit by digit. Any digit >9 (A..F) is loaded as 9.
  - load_err <= 1 if any digit was >9, else 0.
  - When load and en are both high, the load wins and no decrement happens that cycle.
  - A load never sets wrap.
- Count (en=1, load=0):
  - Digit 0 always receives a borrow-in.
  - Digit k decrements when its borrow-in is 1.
  - Digit k, at value 0 with borrow-in 1, becomes 9 and asserts borrow-out to digit k+1.
  - The borrow chain is combinational within one cycle, so latency is one cycle from en to the new q.
  - Examples: 0x20 -> 0x19; 0x100 -> 0x099 for DIGITS=3.
- At q==0 with en=1:
  - stop_at_zero=0: q <= all-9s (0x99 for DIGITS=2), and wrap <= 1 for exactly one cycle.
  - stop_at_zero=1: q holds at 0, and wrap stays 0.
- Hold (en=0, load=0): q unchanged; wrap and load_err return to 0.
- wrap and load_err are 0 in every cycle that does not meet their set conditions; they are never stretched.
- Changing stop_at_zero takes effect on the next qualifying edge. It has no effect when q != 0.
- Reset asserted mid-count aborts immediately; pending wrap/load_err pulses are cleared.
- Cascading: an external counter's en may be driven from wrap. A downstream counter then decrements once per upstream wrap, delayed one cycle.
- q never holds a non-BCD digit under any input sequence.

Decomposition:
- Shared package countd_pkg holds:
  - BCD_MAX = 4'd9 and BCD_W = 4.
  - A function bcd_sat(digit) returning min(digit, 9), used by the load path and by the bench.
- One sub-module, bcd_digit_down, is natural:
  - Inputs: clk, reset, load, ld_digit, bin.
  - Outputs: digit, bout, err.
  - One instance per digit via a generate loop.
- The top level handles the zero decode, the stop_at_zero gating of the borrow-in, and the wrap/load_err registers.

Test Plan:
- Reset: assert reset mid-cycle with no clk edge -> q=0x00, zero=1, wrap=0, load_err=0 immediately.
- Load/count: load 0x25, then en=1 for 6 cycles -> q=0x24,0x23,0x22,0x21,0x20,0x19; zero=0 throughout.
- Wrap: q=0x00, stop_at_zero=0, en=1 -> q=0x99 and wrap=1 for exactly one cycle; next en cycle -> q=0x98, wrap=0.
- Stop-at-zero: q=0x01, stop_at_zero=1, en=1 for 3 cycles -> q=0x00, 0x00, 0x00; zero=1; wrap never asserts.
- Bad load and priority:
  - load 0x3C with en=1 -> q=0x39 (no decrement), load_err=1 for one cycle.
  - load 0x47 -> q=0x47, load_err=0.
- Async reset mid-count: q=0x55 counting, reset pulsed between edges -> q=0x00 at once. First post-reset edge with en=1, stop_at_zero=0 -> q=0x99, wrap=1.

Source files
------------

// File: rtl/countd_pkg.sv
// Shared constants and helpers for the cascadable BCD down counter.
package countd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/countd_bcd_if.sv
// Control/status bundle between a counter user and countd_bcd.
interface countd_bcd_if #(parameter int DIGITS = 2);
    import countd_pkg::*;

    logic                      load;
    logic [BCD_W*DIGITS-1:0]   load_val;
    logic                      en;
    logic                      stop_at_zero;
    logic [BCD_W*DIGITS-1:0]   q;
    logic                      zero;
    logic                      wrap;
    logic                      load_err;

    modport master (
        output load, load_val, en, stop_at_zero,
        input  q, zero, wrap, load_err
    );

    modport slave (
        input  load, load_val, en, stop_at_zero,
        output q, zero, wrap, load_err
    );

endinterface

// File: rtl/countd_bcd_digit.sv
// One BCD digit of the down counter: saturating load, decrement on borrow-in.
module bcd_digit_down
    import countd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_digit,
    input  logic             bin,
    output logic [BCD_W-1:0] digit,
    output logic             bout,
    output logic             err
);

    assign err  = (ld_digit > BCD_MAX);
    assign bout = bin && (digit == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= bcd_sat(ld_digit);
        end else if (bin) begin
            digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/countd_bcd.sv
// Multi-digit BCD down counter with load, stop-at-zero/wrap and chain pulse.
module countd_bcd
    import countd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input logic         clk,
    input logic         reset,
    countd_bcd_if.slave bus
);

    localparam int W = BCD_W * DIGITS;

    logic [W-1:0]      q;
    logic [DIGITS:0]   borrow;
    logic [DIGITS-1:0] err;
    logic              zero;
    logic              wrap;
    logic              load_err;

    assign zero = (q == '0);

    // Gating the chain input covers load priority and the hold-at-zero case.
    assign borrow[0] = bus.en && !bus.load && !(zero && bus.stop_at_zero);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_down u_digit (
            .clk      (clk),
            .reset    (reset),
            .load     (bus.load),
            .ld_digit (bus.load_val[BCD_W*g +: BCD_W]),
            .bin      (borrow[g]),
            .digit    (q[BCD_W*g +: BCD_W]),
            .bout     (borrow[g+1]),
            .err      (err[g])
        );
    end

    // A borrow out of the top digit is exactly a 0 -> all-9s wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= borrow[DIGITS];
            load_err <= bus.load && (|err);
        end
    end

    assign bus.q        = q;
    assign bus.zero     = zero;
    assign bus.wrap     = wrap;
    assign bus.load_err = load_err;

endmodule

// File: tb/tb_countd_bcd.sv
// Randomized self-checking bench for countd_bcd against an integer model.
module tb_countd_bcd;
    import countd_pkg::*;

    localparam int D    = 2;
    localparam int W    = 4 * D;
    localparam int MAXV = 99;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    countd_bcd_if #(.DIGITS(D)) bus ();

    countd_bcd #(.DIGITS(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int mval;
    bit mwrap;
    bit merr;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".q"},    32'(bus.q),        32'(to_bcd(mval)));
        check({tag, ".zero"}, 32'(bus.zero),     32'(mval == 0));
        check({tag, ".wrap"}, 32'(bus.wrap),     32'(mwrap));
        check({tag, ".lerr"}, 32'(bus.load_err), 32'(merr));
    endtask

    // Advance one clock and update the integer model from the sampled inputs.
    task automatic step(input string tag);
        logic [W-1:0] lv;
        int p;
        @(posedge clk);
        mwrap = 1'b0;
        merr  = 1'b0;
        if (bus.load) begin
            lv   = bus.load_val;
            mval = 0;
            p    = 1;
            for (int k = 0; k < D; k++) begin
                if (lv[4*k +: 4] > 4'd9) merr = 1'b1;
                mval = mval + int'(bcd_sat(lv[4*k +: 4])) * p;
                p = p * 10;
            end
        end else if (bus.en) begin
            if (mval == 0) begin
                if (!bus.stop_at_zero) begin
                    mval  = MAXV;
                    mwrap = 1'b1;
                end
            end else begin
                mval = mval - 1;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        mval = 0; mwrap = 1'b0; merr = 1'b0;
        check_all(tag);
        #1 reset = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic e);
        bus.load = 1'b1; bus.load_val = v; bus.en = e;
        step("load");
        bus.load = 1'b0; bus.en = 1'b0;
    endtask

    initial begin
        bus.load = 1'b0;
        bus.load_val = '0;
        bus.en = 1'b0;
        bus.stop_at_zero = 1'b0;
        mval = 0; mwrap = 1'b0; merr = 1'b0;
        #12;
        check_all("rst_hold");
        reset = 1'b0;

        // Load 25 then count down six times.
        do_load(8'h25, 1'b0);
        check("ld25", 32'(bus.q), 32'h25);
        bus.en = 1'b1;
        for (int i = 0; i < 6; i++) step("cnt");
        check("cnt19", 32'(bus.q), 32'h19);

        // Wrap from zero.
        bus.en = 1'b0;
        do_load(8'h00, 1'b0);
        bus.en = 1'b1; bus.stop_at_zero = 1'b0;
        step("wrap");
        check("wrap99", 32'(bus.q), 32'h99);
        check("wrap1", 32'(bus.wrap), 32'd1);
        step("wrap_after");
        check("wrap98", 32'(bus.q), 32'h98);
        check("wrap0", 32'(bus.wrap), 32'd0);

        // Stop at zero.
        bus.en = 1'b0;
        do_load(8'h01, 1'b0);
        bus.en = 1'b1; bus.stop_at_zero = 1'b1;
        for (int i = 0; i < 3; i++) step("saz");
        check("saz_q", 32'(bus.q), 32'h00);

        // Bad load beats enable; clean load clears the error.
        do_load(8'h3C, 1'b1);
        check("bad_q", 32'(bus.q), 32'h39);
        check("bad_err", 32'(bus.load_err), 32'd1);
        do_load(8'h47, 1'b0);
        check("ok_q", 32'(bus.q), 32'h47);
        check("ok_err", 32'(bus.load_err), 32'd0);
        step("hold");

        // Reset between edges while counting.
        do_load(8'h55, 1'b0);
        bus.en = 1'b1; bus.stop_at_zero = 1'b0;
        step("cnt55");
        async_reset("rst_mid");
        step("post_rst");
        check("post_q", 32'(bus.q), 32'h99);
        check("post_wrap", 32'(bus.wrap), 32'd1);

        // Random traffic, with occasional asynchronous reset pulses.
        for (int i = 0; i < 600; i++) begin
            bus.load         = ($urandom_range(7) == 0);
            bus.load_val     = W'($urandom);
            bus.en           = ($urandom_range(3) != 0);
            bus.stop_at_zero = ($urandom_range(1) == 1);
            step("rnd");
            if ($urandom_range(59) == 0) async_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
